// File: rtl/irq_prio_ctrl.sv
// Multi-bus interrupt priority controller: sticky per-channel pending bits, fixed bus priority,
// per-bus channel arbitration. Define IRQ_PRIO_RR_EN for round-robin channel selection within a bus.
module irq_prio_ctrl #(
    parameter int unsigned NBUS = 3,
    parameter int unsigned NCH  = 9,
    parameter int unsigned CHW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       e_in,
    input  logic [NBUS*NCH-1:0]  req_in,
    input  logic                 ack_in,
    output logic                 irq_valid,
    output logic [NBUS-1:0]      bus_out,
    output logic [CHW-1:0]       chan_out,
    output logic                 pend_any
);

    localparam int unsigned NBITS = NBUS * NCH;
    localparam int unsigned BW    = (NBUS > 1) ? $clog2(NBUS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] pend_q, pend_d;
    logic [BW-1:0]    win_bus_q, win_bus_d;
    logic [CHW-1:0]   win_chan_q, win_chan_d;
    logic             irq_valid_q, irq_valid_d;
    logic [NBUS-1:0]  bus_out_q, bus_out_d;
    logic [CHW-1:0]   chan_out_q, chan_out_d;
    logic             pend_any_q, pend_any_d;

    logic [NBITS-1:0] cap_c;
    logic [NBITS-1:0] clr_c;
    logic             arb_found_c;
    logic             hit_c;
    logic [BW-1:0]    arb_bus_c;
    logic [CHW-1:0]   arb_chan_c;
    logic [NCH-1:0]   rot_c;
    int               chan_sum_c;

`ifdef IRQ_PRIO_RR_EN
    logic [CHW-1:0]   ptr_q [NBUS];
    logic [CHW-1:0]   ptr_d [NBUS];
    int               nxt_c;
`endif

    // Requests qualified by the shared per-channel enable
    always_comb begin : capture
        cap_c = '0;
        for (int b = 0; b < int'(NBUS); b++) begin
            cap_c[b*NCH +: NCH] = req_in[b*NCH +: NCH] & e_in;
        end
    end

    // Lowest-numbered busy bus wins; channel search runs from the bus's start point upward
    always_comb begin : arbiter
        arb_found_c = 1'b0;
        hit_c       = 1'b0;
        arb_bus_c   = '0;
        arb_chan_c  = '0;
        rot_c       = '0;
        chan_sum_c  = 0;
        for (int b = 0; b < int'(NBUS); b++) begin
            if (!arb_found_c && (|pend_q[b*NCH +: NCH])) begin
                arb_found_c = 1'b1;
                arb_bus_c   = BW'(b);
`ifdef IRQ_PRIO_RR_EN
                rot_c = NCH'({pend_q[b*NCH +: NCH], pend_q[b*NCH +: NCH]} >> ptr_q[b]);
`else
                rot_c = pend_q[b*NCH +: NCH];
`endif
                for (int k = 0; k < int'(NCH); k++) begin
                    if (!hit_c && rot_c[k]) begin
                        hit_c = 1'b1;
`ifdef IRQ_PRIO_RR_EN
                        chan_sum_c = int'(ptr_q[b]) + k;
                        if (chan_sum_c >= int'(NCH)) begin
                            chan_sum_c = chan_sum_c - int'(NCH);
                        end
`else
                        chan_sum_c = k;
`endif
                        arb_chan_c = CHW'(chan_sum_c);
                    end
                end
            end
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        pend_d     = pend_q | cap_c;
        win_bus_d  = win_bus_q;
        win_chan_d = win_chan_q;
        clr_c      = '0;
`ifdef IRQ_PRIO_RR_EN
        ptr_d = ptr_q;
        nxt_c = 0;
`endif
        for (int b = 0; b < int'(NBUS); b++) begin
            for (int i = 0; i < int'(NCH); i++) begin
                clr_c[b*NCH + i] = (BW'(b) == win_bus_q) && (CHW'(i) == win_chan_q);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pend_any_q) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_found_c) begin
                    win_bus_d  = arb_bus_c;
                    win_chan_d = arb_chan_c;
                    state_d    = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (ack_in) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                // A capture on the granted bit in this cycle keeps it pending
                pend_d = (pend_q & ~clr_c) | cap_c;
`ifdef IRQ_PRIO_RR_EN
                nxt_c = int'(win_chan_q) + 1;
                if (nxt_c >= int'(NCH)) nxt_c = 0;
                for (int b = 0; b < int'(NBUS); b++) begin
                    if (BW'(b) == win_bus_q) ptr_d[b] = CHW'(nxt_c);
                end
`endif
                state_d = (|pend_d) ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        irq_valid_d = (state_d == S_GRANT);
        bus_out_d   = '0;
        chan_out_d  = '0;
        if (irq_valid_d) begin
            for (int b = 0; b < int'(NBUS); b++) begin
                bus_out_d[b] = (BW'(b) == win_bus_d);
            end
            chan_out_d = win_chan_d;
        end
        pend_any_d = |pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            win_bus_q   <= '0;
            win_chan_q  <= '0;
            irq_valid_q <= 1'b0;
            bus_out_q   <= '0;
            chan_out_q  <= '0;
            pend_any_q  <= 1'b0;
`ifdef IRQ_PRIO_RR_EN
            for (int b = 0; b < int'(NBUS); b++) begin
                ptr_q[b] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            win_bus_q   <= win_bus_d;
            win_chan_q  <= win_chan_d;
            irq_valid_q <= irq_valid_d;
            bus_out_q   <= bus_out_d;
            chan_out_q  <= chan_out_d;
            pend_any_q  <= pend_any_d;
`ifdef IRQ_PRIO_RR_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign irq_valid = irq_valid_q;
    assign bus_out   = bus_out_q;
    assign chan_out  = chan_out_q;
    assign pend_any  = pend_any_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_irq_prio_ctrl;

    localparam int NBUS  = 3;
    localparam int NCH   = 9;
    localparam int CHW   = 4;
    localparam int NBITS = NBUS * NCH;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   e_in;
    logic [NBITS-1:0] req_in;
    logic             ack_in;
    logic             irq_valid;
    logic [NBUS-1:0]  bus_out;
    logic [CHW-1:0]   chan_out;
    logic             pend_any;

    irq_prio_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .e_in      (e_in),
        .req_in    (req_in),
        .ack_in    (ack_in),
        .irq_valid (irq_valid),
        .bus_out   (bus_out),
        .chan_out  (chan_out),
        .pend_any  (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARB = 1, M_GRANT = 2, M_CLEAR = 3;
    bit m_pend [NBUS][NCH];
    int m_ptr  [NBUS];
    int m_ph = M_IDLE;
    int m_gb = 0;
    int m_gc = 0;

    function automatic bit m_any();
        for (int b = 0; b < NBUS; b++)
            for (int i = 0; i < NCH; i++)
                if (m_pend[b][i]) return 1'b1;
        return 1'b0;
    endfunction

    // Highest-priority bus first, then first pending channel scanning from the bus's start point
    function automatic void m_pick();
        for (int b = 0; b < NBUS; b++) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr[b] + k) % NCH;
                if (m_pend[b][c]) begin
                    m_gb = b;
                    m_gc = c;
                    return;
                end
            end
        end
    endfunction

    function automatic void m_capture();
        for (int b = 0; b < NBUS; b++)
            for (int i = 0; i < NCH; i++)
                if (req_in[b*NCH + i] && e_in[i]) m_pend[b][i] = 1'b1;
    endfunction

    function automatic void model_edge();
        bit old_any;
        old_any = m_any();
        if (rst) begin
            for (int b = 0; b < NBUS; b++) begin
                m_ptr[b] = 0;
                for (int i = 0; i < NCH; i++) m_pend[b][i] = 1'b0;
            end
            m_ph = M_IDLE;
            return;
        end
        case (m_ph)
            M_IDLE: begin
                m_capture();
                if (old_any) m_ph = M_ARB;
            end
            M_ARB: begin
                if (old_any) begin
                    m_pick();
                    m_ph = M_GRANT;
                end else begin
                    m_ph = M_IDLE;
                end
                m_capture();
            end
            M_GRANT: begin
                m_capture();
                if (ack_in) m_ph = M_CLEAR;
            end
            default: begin
                m_pend[m_gb][m_gc] = 1'b0;
                m_capture();
`ifdef IRQ_PRIO_RR_EN
                m_ptr[m_gb] = (m_gc + 1) % NCH;
`endif
                m_ph = m_any() ? M_ARB : M_IDLE;
            end
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit r, input logic [NCH-1:0] e, input logic [NBITS-1:0] q, input bit a);
        rst    = r;
        e_in   = e;
        req_in = q;
        ack_in = a;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input int v, input int b, input int c, input int p);
        chk({name, ".irq_valid"}, int'(irq_valid), v);
        chk({name, ".bus_out"},   int'(bus_out),   b);
        chk({name, ".chan_out"},  int'(chan_out),  c);
        chk({name, ".pend_any"},  int'(pend_any),  p);
    endtask

    task automatic chk_model(input string name);
        bit g;
        g = (m_ph == M_GRANT);
        chk_out(name, int'(g), g ? (1 << m_gb) : 0, g ? m_gc : 0, int'(m_any()));
    endtask

    typedef struct {
        bit               r;
        logic [NCH-1:0]   e;
        logic [NBITS-1:0] q;
        bit               a;
        int               v;
        int               b;
        int               c;
        int               p;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input logic [NCH-1:0] e, input logic [NBITS-1:0] q,
                                input bit a, input int v, input int b, input int c, input int p);
        vec_t t;
        t.r = r; t.e = e; t.q = q; t.a = a;
        t.v = v; t.b = b; t.c = c; t.p = p;
        tbl.push_back(t);
    endfunction

    logic [NBITS-1:0] all_req;
    logic [NBITS-1:0] three_req;

    initial begin
        all_req   = '1;
        three_req = {9'h002, 9'h002, 9'h002};
        drive(1'b1, '1, '0, 1'b0);

        // reset with simultaneous requests discards them
        add(1, 9'h1FF, all_req,   0, 0, 0, 0, 0);
        add(0, 9'h1FF, '0,        0, 0, 0, 0, 0);
        // three buses request channel 1: served bus 0, 1, 2 in order
        add(0, 9'h1FF, three_req, 0, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 1, 1, 1, 1);
        add(0, 9'h1FF, '0,        1, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 1, 2, 1, 1);
        add(0, 9'h1FF, '0,        1, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 1, 4, 1, 1);
        add(0, 9'h1FF, '0,        1, 0, 0, 0, 1);
        add(0, 9'h1FF, '0,        0, 0, 0, 0, 0);
        add(0, 9'h1FF, '0,        1, 0, 0, 0, 0);
        // all channels disabled: nothing captured
        add(0, 9'h000, all_req,   1, 0, 0, 0, 0);
        add(0, 9'h000, all_req,   0, 0, 0, 0, 0);
        add(0, 9'h000, all_req,   0, 0, 0, 0, 0);
        add(0, 9'h000, all_req,   0, 0, 0, 0, 0);
        add(0, 9'h004, {9'h000, 9'h004, 9'h000}, 0, 0, 0, 0, 1);
        add(0, 9'h004, '0,        0, 0, 0, 0, 1);
        add(0, 9'h004, '0,        0, 1, 2, 2, 1);
        add(0, 9'h004, '0,        1, 0, 0, 0, 1);
        add(0, 9'h004, '0,        0, 0, 0, 0, 0);

        foreach (tbl[n]) begin
            drive(tbl[n].r, tbl[n].e, tbl[n].q, tbl[n].a);
            step();
            chk_out($sformatf("tbl%0d", n), tbl[n].v, tbl[n].b, tbl[n].c, tbl[n].p);
        end

        // new capture during a grant does not disturb the presented grant
        drive(1, 9'h1FF, '0, 0); step();
        drive(0, 9'h1FF, 27'(9'h008), 0); step(); chk_out("col_cap", 0, 0, 0, 1);
        drive(0, 9'h1FF, '0, 0); step(); step(); chk_out("col_g0", 1, 1, 3, 1);
        drive(0, 9'h1FF, {9'h001, 9'h000, 9'h000}, 0); step(); chk_out("col_hold1", 1, 1, 3, 1);
        drive(0, 9'h1FF, '0, 0); step(); chk_out("col_hold2", 1, 1, 3, 1);
        drive(0, 9'h1FF, '0, 1); step(); chk_out("col_clr", 0, 0, 0, 1);
        drive(0, 9'h1FF, '0, 0); step(); chk_out("col_arb", 0, 0, 0, 1);
        step(); chk_out("col_g2", 1, 4, 0, 1);
        drive(0, 9'h1FF, '0, 1); step(); step(); chk_out("col_idle", 0, 0, 0, 0);

        // re-request on the granted bit during the clear cycle is granted again
        drive(1, 9'h1FF, '0, 0); step();
        drive(0, 9'h1FF, 27'(9'h008), 0); step();
        drive(0, 9'h1FF, '0, 0); step(); step(); chk_out("rereq_g", 1, 1, 3, 1);
        drive(0, 9'h1FF, '0, 1); step(); chk_out("rereq_clr", 0, 0, 0, 1);
        drive(0, 9'h1FF, 27'(9'h008), 0); step(); chk_out("rereq_arb", 0, 0, 0, 1);
        drive(0, 9'h1FF, '0, 0); step(); chk_out("rereq_g2", 1, 1, 3, 1);

        // reset mid-grant with three bits pending
        drive(1, 9'h1FF, '0, 0); step();
        drive(0, 9'h1FF, {9'h100, 9'h020, 9'h002}, 0); step();
        drive(0, 9'h1FF, '0, 0); step(); step(); chk_out("rstg_g", 1, 1, 1, 1);
        drive(1, 9'h1FF, '0, 0); step(); chk_out("rstg_rst", 0, 0, 0, 0);
        drive(0, 9'h1FF, '0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out($sformatf("rstg_after%0d", k), 0, 0, 0, 0);
        end

        // bus 0 fully requesting with continuous ack: channel rotation vs fixed priority
        drive(1, 9'h1FF, '0, 0); step();
        drive(0, 9'h1FF, 27'(9'h1FF), 1);
        step(); step(); step();
        chk_out("rot0", 1, 1, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            int exp_c;
`ifdef IRQ_PRIO_RR_EN
            exp_c = k % NCH;
`else
            exp_c = 0;
`endif
            step(); step(); step();
            chk_out($sformatf("rot%0d", k), 1, 1, exp_c, 1);
        end

        // randomized traffic against the model
        drive(1, 9'h1FF, '0, 0); step();
        for (int n = 0; n < 600; n++) begin
            logic [NBITS-1:0] q;
            logic [NCH-1:0]   e;
            q = NBITS'($urandom & $urandom & $urandom);
            e = NCH'($urandom | $urandom);
            drive(($urandom_range(0, 99) == 0), e, q, 1'($urandom_range(0, 1)));
            step();
            chk_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 Parameter NBUS, default 3: number of request buses; bus 0 has highest priority, bus NBUS-1 lowest.
REQ-002 Parameter NCH, default 9: channels per bus; legal range 2..32.
REQ-003 Parameter CHW, default $clog2(NCH): channel-index width, 4 at defaults.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 e_in  input  NCH  per-channel enable, common to all buses.
REQ-007 req_in  input  NBUS*NCH  request vector; bus b occupies bits [b*NCH +: NCH].
REQ-008 ack_in  input  1  acknowledge from the consumer of the current grant.
REQ-009 irq_valid  output  1  a grant is presented and held.
REQ-010 bus_out  output  NBUS  one-hot granted bus, equivalent to PA/PB/PC at defaults; all zero when irq_valid=0.
REQ-011 chan_out  output  CHW  index of the granted channel within the granted bus; zero when irq_valid=0.
REQ-012 pend_any  output  1  OR of all pending bits.

Function
REQ-013 Capture: at each edge, pend[b][i] SHALL be set when req_in[b*NCH+i] & e_in[i] = 1.
- Pending bits are sticky until cleared per REQ-018.
- A later deassertion of req_in or e_in does not clear a pending bit.
REQ-014 The FSM SHALL have states IDLE, ARB, GRANT and CLEAR.
REQ-015 IDLE: go to ARB when pend_any=1; otherwise stay in IDLE.
REQ-016 ARB: select the lowest-numbered bus with any pending bit, then the winning channel in that bus per REQ-022.
- Register the result into bus_out and chan_out.
- Go to GRANT.
- If no bit is pending, go to IDLE.
REQ-017 GRANT: irq_valid=1.
- bus_out and chan_out are frozen while in GRANT.
- New captures update pend but not the outputs.
- ack_in=1 moves the FSM to CLEAR.
REQ-018 CLEAR: irq_valid=0; clear the granted pending bit.
- If a new capture hits the same bit in the same cycle, set wins and the bit stays pending.
- Next state is ARB if pend_any is 1 after the update, otherwise IDLE.
REQ-019 Latency: a request sampled at edge N in IDLE SHALL give irq_valid=1 after edge N+2.
REQ-020 Back-to-back grants: irq_valid SHALL deassert for exactly 2 cycles (CLEAR, ARB) between consecutive grants.
REQ-021 ack_in SHALL be ignored in IDLE, ARB and CLEAR.
REQ-022 Channel priority within a bus: index 0 is highest, unless modified per REQ-026.

Reset
REQ-023 When rst=1 at an edge, the block SHALL go to IDLE and clear all pend bits.
- Outputs: irq_valid=0, bus_out=0, chan_out=0, pend_any=0.
- Requests presented in the same cycle as rst are discarded.
REQ-024 rst asserted mid-grant SHALL abort the grant without requiring ack_in.
REQ-025 The first capture SHALL occur at the first edge with rst=0.

Configuration
REQ-026 Macro IRQ_PRIO_RR_EN.
- Defined: each bus keeps a CHW-bit rotation pointer, reset to 0.
- On CLEAR, the granted bus's pointer becomes (chan_out+1) mod NCH.
- Channel search starts at the pointer and wraps from NCH-1 to 0.
- Undefined: fixed priority per REQ-022, and no pointer registers are present.

Verification
REQ-027 Defaults, all e_in=1, req_in bus0=9'h002, bus1=9'h002, bus2=9'h002 for one cycle:
- irq_valid=1 two cycles later, bus_out=3'b001, chan_out=1.
- After ack: bus 1 granted, then bus 2, then pend_any=0 and the FSM in IDLE.
REQ-028 e_in=9'h000 with any req_in: pend_any stays 0 and irq_valid never asserts.
- Then e_in=9'h004 with bus1=9'h004: grant bus_out=3'b010, chan_out=2.
REQ-029 Collision cases:
- Bus2 bit 0 arrives during an active GRANT on bus 0: outputs are unchanged until ack_in, and bus 2 is granted next.
- A re-request on the granted bit in the CLEAR cycle: the same channel is granted again.
REQ-030 rst asserted while irq_valid=1 with 3 bits pending: next cycle all outputs are 0 and pend_any=0.
- No grant follows without new requests.
REQ-031 With IRQ_PRIO_RR_EN, bus0=9'h1FF held continuously and ack_in=1 each GRANT cycle: chan_out sequence is 0,1,...,8,0.
- Without the macro, chan_out stays at 0 throughout.
